// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller: default sizes and the
// per-cycle operation encoding used to steer the occupancy counter.
package fifo_ctrl_pkg;

  localparam int DEFAULT_DATA_BITS = 10;
  localparam int DEFAULT_ADDR_BITS = 3;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Build the operation code from the accepted push/pop strobes.
  function automatic fifo_op_e make_op(input logic push_ok, input logic pop_ok);
    return fifo_op_e'({pop_ok, push_ok});
  endfunction

endpackage

// File: rtl/fifo_ctrl_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module fifo_ctrl_ram
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 write,
  input  logic                 read,
  input  logic [ADDR_BITS-1:0] addr_write,
  input  logic [ADDR_BITS-1:0] addr_read,
  input  logic [DATA_BITS-1:0] data_write,
  output logic [DATA_BITS-1:0] data_read
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // Write and registered read share the edge, so a same-address read sees the old contents.
  always_ff @(posedge clk) begin
    if (write) mem[addr_write] <= data_write;
    if (read)  data_read <= mem[addr_read];
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointers, occupancy count, flags and sticky error bits
// around a single dual-port RAM with one cycle of read latency.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [ADDR_BITS:0]   umbral_af,
  input  logic [ADDR_BITS:0]   umbral_ae,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;
  fifo_op_e             op;

  // Flags come straight from the registered count so they never glitch on inputs.
  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= umbral_af);
  assign almost_empty = (count <= umbral_ae);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a paired push.
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    op      = make_op(push_ok, pop_ok);
  end

  // Pointer, count, read-valid and sticky error state; reset wins over any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: count <= count;
      endcase
      valid_out <= pop_ok;
      if (push && full && !pop_ok) overflow  <= 1'b1;
      if (pop && empty)            underflow <= 1'b1;
    end
  end

  fifo_ctrl_ram #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk        (clk),
    .write      (push_ok),
    .read       (pop_ok),
    .addr_write (wr_ptr),
    .addr_read  (rd_ptr),
    .data_write (data_in),
    .data_read  (data_out)
  );

endmodule
